mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-to-one cache-line memory arbiter between the Aquila core's instruction and data memory master ports and a single external cache-line memory port. It accepts I-side line reads and D-side line reads/writes, grants one at a time with round-robin fairness, and registers the request toward memory. It returns completion and read data to the winning side. A watchdog guarantees every request completes.

## Interface
- XLEN, 32, address width.
- CLSIZE, `CLP, cache-line width in bits.
- TIMEOUT_CYCLES, 1024, max cycles waiting for M_MEM_done_i; 0 disables the watchdog.

- clk_i  in  1  single clock; all logic on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- S_IMEM_strobe_i  in  1  I-side line read request (level).
- S_IMEM_addr_i  in  XLEN  I-side line address.
- S_IMEM_done_o  out  1  I-side completion pulse.
- S_IMEM_data_o  out  CLSIZE  I-side read line.
- S_DMEM_strobe_i  in  1  D-side request (level).
- S_DMEM_addr_i  in  XLEN  D-side line address.
- S_DMEM_rw_i  in  1  1 = write, 0 = read.
- S_DMEM_data_i  in  CLSIZE  D-side write line.
- S_DMEM_done_o  out  1  D-side completion pulse.
- S_DMEM_data_o  out  CLSIZE  D-side read line.
- M_MEM_strobe_o  out  1  external request, held until done or timeout.
- M_MEM_addr_o  out  XLEN  latched address.
- M_MEM_rw_o  out  1  latched direction.
- M_MEM_data_o  out  CLSIZE  latched write line.
- M_MEM_done_i  in  1  external completion; read data valid in the same cycle.
- M_MEM_data_i  in  CLSIZE  external read line.
- timeout_o  out  1  sticky watchdog flag.

## Operation
- Requester contract: the strobe is held high, with address, rw, and data stable, until the cycle done_o is high. The strobe drops in the following cycle.
- States:
  - IDLE: no outstanding request.
  - BUSY: M_MEM_strobe_o = 1.
  - RESP: one-cycle completion to the granted side.
- IDLE, exactly one strobe high: grant that side, latch addr/rw/data, and go to BUSY. The I-side always uses rw = 0.
- IDLE, both strobes high: grant the side opposite last_grant. last_grant resets to I, so D wins the first tie.
- last_grant updates on every grant.
- A strobe raised while BUSY/RESP is not latched. It is evaluated in IDLE after RESP.
- BUSY, M_MEM_done_i = 1: on a read, latch M_MEM_data_i into the granted side's data_o register. Go to RESP.
- BUSY, watchdog count reaches TIMEOUT_CYCLES without M_MEM_done_i:
  - drop M_MEM_strobe_o;
  - set the granted side's data_o to 0;
  - set timeout_o = 1;
  - go to RESP.
- RESP: assert only the granted side's done_o, then go to IDLE.
- Writes also return done_o; data_o is 0 for writes.
- The watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits and clears on entry to BUSY.
- timeout_o clears only on reset.
- M_MEM_done_i outside BUSY is ignored.

## Timing
- Reset (async assert, deasserted synchronously by the environment):
  - state = IDLE, last_grant = I;
  - all outputs 0, including latched addr/data and timeout_o.
- Reset mid-transaction aborts it; no done_o is produced.
- Strobe sampled high in cycle 0 (IDLE) → M_MEM_strobe_o high from cycle 1.
- M_MEM_done_i in cycle k ≥ 1 → M_MEM_strobe_o low in cycle k+1, done_o high for exactly cycle k+1 (data_o valid then), state IDLE in cycle k+2.
- Minimum turnaround: a new grant can be sampled in cycle k+2, with M_MEM_strobe_o high again in k+3.
- Zero-wait memory (done in cycle 1): 3-cycle request-to-request latency per line.
- Timeout: with strobe first high in cycle 1, done_o is high in cycle TIMEOUT_CYCLES+2.
- done_o never high on both sides in the same cycle.
- M_MEM_* outputs stay stable for the whole of BUSY.

## Test plan
- Single I read, addr 0x8000_0040, memory done in cycle 3 with line 0xA5..A5:
  - M_MEM_strobe_o high cycles 1–3, rw = 0;
  - S_IMEM_done_o high cycle 4 only, data = 0xA5..A5.
- Simultaneous I read 0x8000_0000 and D write 0x8000_1000 after reset:
  - D is granted first (M_MEM_rw_o = 1, data forwarded), then I;
  - S_IMEM_done_o never high while S_DMEM_done_o is high.
- Both strobes re-asserted continuously for 4 transactions: grants alternate D, I, D, I.
- TIMEOUT_CYCLES = 8, M_MEM_done_i held low:
  - S_DMEM_done_o high in cycle 10, data = 0;
  - timeout_o = 1 and stays 1 across later normal transactions until rst_ni is low.
- rst_ni asserted in cycle 2 of a BUSY read:
  - all outputs 0 immediately;
  - no done_o;
  - after release, a new I read completes normally.
- Spurious M_MEM_done_i while IDLE: no done_o, no state change.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the two core-side requesters and the
// external cache-line memory port. The slave modport is the arbiter's view;
// the master modport is the view of the surrounding core and memory.
interface mem_arbiter_if #(
    parameter int XLEN   = 32,
    parameter int CLSIZE = 128
);
    logic              S_IMEM_strobe_i;
    logic [XLEN-1:0]   S_IMEM_addr_i;
    logic              S_IMEM_done_o;
    logic [CLSIZE-1:0] S_IMEM_data_o;

    logic              S_DMEM_strobe_i;
    logic [XLEN-1:0]   S_DMEM_addr_i;
    logic              S_DMEM_rw_i;
    logic [CLSIZE-1:0] S_DMEM_data_i;
    logic              S_DMEM_done_o;
    logic [CLSIZE-1:0] S_DMEM_data_o;

    logic              M_MEM_strobe_o;
    logic [XLEN-1:0]   M_MEM_addr_o;
    logic              M_MEM_rw_o;
    logic [CLSIZE-1:0] M_MEM_data_o;
    logic              M_MEM_done_i;
    logic [CLSIZE-1:0] M_MEM_data_i;

    modport slave (
        input  S_IMEM_strobe_i, S_IMEM_addr_i,
        output S_IMEM_done_o, S_IMEM_data_o,
        input  S_DMEM_strobe_i, S_DMEM_addr_i, S_DMEM_rw_i, S_DMEM_data_i,
        output S_DMEM_done_o, S_DMEM_data_o,
        output M_MEM_strobe_o, M_MEM_addr_o, M_MEM_rw_o, M_MEM_data_o,
        input  M_MEM_done_i, M_MEM_data_i
    );

    modport master (
        output S_IMEM_strobe_i, S_IMEM_addr_i,
        input  S_IMEM_done_o, S_IMEM_data_o,
        output S_DMEM_strobe_i, S_DMEM_addr_i, S_DMEM_rw_i, S_DMEM_data_i,
        input  S_DMEM_done_o, S_DMEM_data_o,
        input  M_MEM_strobe_o, M_MEM_addr_o, M_MEM_rw_o, M_MEM_data_o,
        output M_MEM_done_i, M_MEM_data_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-to-one cache-line memory arbiter: I-side reads and D-side reads/writes
// share one external line port. Round-robin on ties, one transaction at a
// time, with a watchdog that forces completion if memory never answers.
module mem_arbiter #(
    parameter int XLEN           = 32,
    parameter int CLSIZE         = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mem_arbiter_if.slave  bus,
    output logic          timeout_o
);
    // A zero timeout disables the watchdog; keep the counter at least 1 bit wide.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              grant_d;
    logic [CNT_W-1:0]  wd_count;
    logic              do_grant;
    logic              pick_d;
    logic              mem_done;
    logic              wd_expire;
    logic [XLEN-1:0]   addr_q;
    logic              rw_q;
    logic [CLSIZE-1:0] wdata_q;
    logic [CLSIZE-1:0] idata_q;
    logic [CLSIZE-1:0] ddata_q;
    logic              timeout_q;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, grant decision and the state-decoded handshake outputs.
    always_comb begin
        next_state         = state;
        do_grant           = 1'b0;
        pick_d             = 1'b0;
        mem_done           = 1'b0;
        wd_expire          = 1'b0;
        bus.M_MEM_strobe_o = 1'b0;
        bus.S_IMEM_done_o  = 1'b0;
        bus.S_DMEM_done_o  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.S_IMEM_strobe_i || bus.S_DMEM_strobe_i) begin
                    do_grant   = 1'b1;
                    next_state = BUSY;
                    if (bus.S_IMEM_strobe_i && bus.S_DMEM_strobe_i) begin
                        pick_d = ~grant_d;
                    end else begin
                        pick_d = bus.S_DMEM_strobe_i;
                    end
                end
            end
            BUSY: begin
                bus.M_MEM_strobe_o = 1'b1;
                if (bus.M_MEM_done_i) begin
                    mem_done   = 1'b1;
                    next_state = RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (wd_count == WD_LIMIT)) begin
                    wd_expire  = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                bus.S_IMEM_done_o = ~grant_d;
                bus.S_DMEM_done_o = grant_d;
                next_state        = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latch the winning request; the I side is always a read with no write line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_d <= 1'b0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
        end else if (do_grant) begin
            grant_d <= pick_d;
            addr_q  <= pick_d ? bus.S_DMEM_addr_i : bus.S_IMEM_addr_i;
            rw_q    <= pick_d & bus.S_DMEM_rw_i;
            wdata_q <= pick_d ? bus.S_DMEM_data_i : '0;
        end
    end

    // Watchdog counts BUSY cycles without a memory answer, restarting on each grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_count <= '0;
        end else if (do_grant) begin
            wd_count <= '0;
        end else if ((state == BUSY) && !bus.M_MEM_done_i) begin
            wd_count <= wd_count + CNT_W'(1);
        end
    end

    // Return-line registers: read data on completion, zero for writes and timeouts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idata_q <= '0;
            ddata_q <= '0;
        end else if (mem_done) begin
            if (grant_d) begin
                ddata_q <= rw_q ? '0 : bus.M_MEM_data_i;
            end else begin
                idata_q <= bus.M_MEM_data_i;
            end
        end else if (wd_expire) begin
            if (grant_d) begin
                ddata_q <= '0;
            end else begin
                idata_q <= '0;
            end
        end
    end

    // Sticky watchdog flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_q <= 1'b0;
        end else if (wd_expire) begin
            timeout_q <= 1'b1;
        end
    end

    assign bus.M_MEM_addr_o  = addr_q;
    assign bus.M_MEM_rw_o    = rw_q;
    assign bus.M_MEM_data_o  = wdata_q;
    assign bus.S_IMEM_data_o = idata_q;
    assign bus.S_DMEM_data_o = ddata_q;
    assign timeout_o         = timeout_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single reads, tie-break order, round-robin,
// watchdog timeout, mid-transaction reset and spurious memory completion.
module tb_mem_arbiter;
    logic clk;
    logic rst_n;
    logic timeout;
    int   total = 0;
    int   bad   = 0;

    localparam logic [127:0] LINE_A5 = {16{8'hA5}};
    localparam logic [127:0] WLINE   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] RLINE   = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] JUNK    = {16{8'h77}};
    localparam logic [31:0]  RR_IA   = 32'h8000_0100;
    localparam logic [31:0]  RR_DA   = 32'h8000_0200;

    mem_arbiter_if #(.XLEN(32), .CLSIZE(128)) bus ();

    mem_arbiter #(
        .XLEN(32),
        .CLSIZE(128),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus.slave),
        .timeout_o (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic istb, input logic [31:0] iaddr,
                                 input logic dstb, input logic [31:0] daddr,
                                 input logic drw, input logic [127:0] ddata);
        bus.S_IMEM_strobe_i = istb;
        bus.S_IMEM_addr_i   = iaddr;
        bus.S_DMEM_strobe_i = dstb;
        bus.S_DMEM_addr_i   = daddr;
        bus.S_DMEM_rw_i     = drw;
        bus.S_DMEM_data_i   = ddata;
    endtask

    task automatic memReply(input logic done, input logic [127:0] data);
        bus.M_MEM_done_i = done;
        bus.M_MEM_data_i = data;
    endtask

    task automatic doReset;
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 128'h0);
        memReply(1'b0, 128'h0);
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mstb"},  bus.M_MEM_strobe_o, 0);
        checkOutput({tag, "_maddr"}, bus.M_MEM_addr_o, 0);
        checkOutput({tag, "_mrw"},   bus.M_MEM_rw_o, 0);
        checkOutput({tag, "_mdata"}, bus.M_MEM_data_o, 0);
        checkOutput({tag, "_idone"}, bus.S_IMEM_done_o, 0);
        checkOutput({tag, "_ddone"}, bus.S_DMEM_done_o, 0);
        checkOutput({tag, "_idata"}, bus.S_IMEM_data_o, 0);
        checkOutput({tag, "_ddata"}, bus.S_DMEM_data_o, 0);
        checkOutput({tag, "_tmo"},   timeout, 0);
    endtask

    // Both completion pulses must never coincide.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("excl_done", bus.S_IMEM_done_o & bus.S_DMEM_done_o, 0);
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 128'h0);
        memReply(1'b0, 128'h0);
        #2;
        checkAllZero("rst");
        doReset;
        checkAllZero("rst_rel");

        // Single I read, memory answers in cycle 3.
        applyStimulus(1'b1, 32'h8000_0040, 1'b0, 32'h0, 1'b0, 128'h0);
        tick;
        checkOutput("i1_stb_c1", bus.M_MEM_strobe_o, 1);
        checkOutput("i1_addr",   bus.M_MEM_addr_o, 32'h8000_0040);
        checkOutput("i1_rw",     bus.M_MEM_rw_o, 0);
        tick;
        checkOutput("i1_stb_c2", bus.M_MEM_strobe_o, 1);
        checkOutput("i1_done_c2", bus.S_IMEM_done_o, 0);
        tick;
        checkOutput("i1_stb_c3", bus.M_MEM_strobe_o, 1);
        memReply(1'b1, LINE_A5);
        tick;
        memReply(1'b0, 128'h0);
        checkOutput("i1_stb_c4",  bus.M_MEM_strobe_o, 0);
        checkOutput("i1_done_c4", bus.S_IMEM_done_o, 1);
        checkOutput("i1_data",    bus.S_IMEM_data_o, LINE_A5);
        checkOutput("i1_ddone",   bus.S_DMEM_done_o, 0);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 128'h0);
        checkOutput("i1_done_c5", bus.S_IMEM_done_o, 0);
        tick;
        checkOutput("i1_stb_c6", bus.M_MEM_strobe_o, 0);

        // Tie after reset: D write first, then I read.
        doReset;
        applyStimulus(1'b1, 32'h8000_0000, 1'b1, 32'h8000_1000, 1'b1, WLINE);
        tick;
        checkOutput("tie_stb1",  bus.M_MEM_strobe_o, 1);
        checkOutput("tie_rw1",   bus.M_MEM_rw_o, 1);
        checkOutput("tie_addr1", bus.M_MEM_addr_o, 32'h8000_1000);
        checkOutput("tie_wdata", bus.M_MEM_data_o, WLINE);
        memReply(1'b1, JUNK);
        tick;
        memReply(1'b0, 128'h0);
        checkOutput("tie_ddone", bus.S_DMEM_done_o, 1);
        checkOutput("tie_idone", bus.S_IMEM_done_o, 0);
        checkOutput("tie_wr_data0", bus.S_DMEM_data_o, 0);
        checkOutput("tie_stb_off", bus.M_MEM_strobe_o, 0);
        tick;
        applyStimulus(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 128'h0);
        checkOutput("tie_ddone_off", bus.S_DMEM_done_o, 0);
        tick;
        checkOutput("tie_stb2",  bus.M_MEM_strobe_o, 1);
        checkOutput("tie_rw2",   bus.M_MEM_rw_o, 0);
        checkOutput("tie_addr2", bus.M_MEM_addr_o, 32'h8000_0000);
        checkOutput("tie_mdata2", bus.M_MEM_data_o, 0);
        memReply(1'b1, RLINE);
        tick;
        memReply(1'b0, 128'h0);
        checkOutput("tie_idone2", bus.S_IMEM_done_o, 1);
        checkOutput("tie_ddone2", bus.S_DMEM_done_o, 0);
        checkOutput("tie_idata2", bus.S_IMEM_data_o, RLINE);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 128'h0);
        tick;

        // Round-robin: both sides keep requesting; grants go D, I, D, I.
        doReset;
        applyStimulus(1'b1, RR_IA, 1'b1, RR_DA, 1'b0, 128'h0);
        tick;
        for (int n = 0; n < 4; n++) begin
            logic         exp_d;
            logic [127:0] line;
            exp_d = (n % 2 == 0);
            line  = {4{32'h0000_0000 + 32'(n + 1) * 32'h1010_1010}};
            if (n > 0) begin
                applyStimulus(1'b1, RR_IA, 1'b1, RR_DA, 1'b0, 128'h0);
            end
            checkOutput($sformatf("rr%0d_stb", n), bus.M_MEM_strobe_o, 1);
            checkOutput($sformatf("rr%0d_addr", n), bus.M_MEM_addr_o, exp_d ? RR_DA : RR_IA);
            memReply(1'b1, line);
            tick;
            memReply(1'b0, 128'h0);
            checkOutput($sformatf("rr%0d_ddone", n), bus.S_DMEM_done_o, exp_d);
            checkOutput($sformatf("rr%0d_idone", n), bus.S_IMEM_done_o, !exp_d);
            checkOutput($sformatf("rr%0d_data", n),
                        exp_d ? bus.S_DMEM_data_o : bus.S_IMEM_data_o, line);
            tick;
            if (n == 3) begin
                applyStimulus(1'b0, RR_IA, 1'b0, RR_DA, 1'b0, 128'h0);
            end else if (exp_d) begin
                applyStimulus(1'b1, RR_IA, 1'b0, RR_DA, 1'b0, 128'h0);
            end else begin
                applyStimulus(1'b0, RR_IA, 1'b1, RR_DA, 1'b0, 128'h0);
            end
            tick;
        end
        checkOutput("rr_end_stb", bus.M_MEM_strobe_o, 0);

        // Watchdog: D read with memory silent, done in cycle 10.
        doReset;
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_2000, 1'b0, 128'h0);
        tick;
        for (int c = 1; c <= 9; c++) begin
            checkOutput($sformatf("wd_c%0d_stb", c), bus.M_MEM_strobe_o, 1);
            checkOutput($sformatf("wd_c%0d_done", c), bus.S_DMEM_done_o, 0);
            checkOutput($sformatf("wd_c%0d_tmo", c), timeout, 0);
            tick;
        end
        checkOutput("wd_c10_done", bus.S_DMEM_done_o, 1);
        checkOutput("wd_c10_data", bus.S_DMEM_data_o, 0);
        checkOutput("wd_c10_stb",  bus.M_MEM_strobe_o, 0);
        checkOutput("wd_c10_tmo",  timeout, 1);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 128'h0);
        checkOutput("wd_c11_done", bus.S_DMEM_done_o, 0);
        tick;
        applyStimulus(1'b1, 32'h8000_3000, 1'b0, 32'h0, 1'b0, 128'h0);
        tick;
        checkOutput("wd_next_stb", bus.M_MEM_strobe_o, 1);
        memReply(1'b1, RLINE);
        tick;
        memReply(1'b0, 128'h0);
        checkOutput("wd_next_done", bus.S_IMEM_done_o, 1);
        checkOutput("wd_next_data", bus.S_IMEM_data_o, RLINE);
        checkOutput("wd_next_tmo",  timeout, 1);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 128'h0);
        tick;
        checkOutput("wd_sticky", timeout, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("wd_rst_clear", timeout, 0);
        tick;
        tick;
        rst_n = 1'b1;

        // Reset in cycle 2 of a BUSY read aborts it.
        applyStimulus(1'b1, 32'h8000_4000, 1'b0, 32'h0, 1'b0, 128'h0);
        tick;
        checkOutput("mr_stb_c1", bus.M_MEM_strobe_o, 1);
        tick;
        rst_n = 1'b0;
        #1;
        checkAllZero("mr_rst");
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 128'h0);
        tick;
        checkOutput("mr_idone_a", bus.S_IMEM_done_o, 0);
        tick;
        rst_n = 1'b1;
        checkOutput("mr_idone_b", bus.S_IMEM_done_o, 0);
        tick;
        checkOutput("mr_idone_c", bus.S_IMEM_done_o, 0);
        checkOutput("mr_stb_idle", bus.M_MEM_strobe_o, 0);
        applyStimulus(1'b1, 32'h8000_5000, 1'b0, 32'h0, 1'b0, 128'h0);
        tick;
        checkOutput("mr_new_stb",  bus.M_MEM_strobe_o, 1);
        checkOutput("mr_new_addr", bus.M_MEM_addr_o, 32'h8000_5000);
        memReply(1'b1, WLINE);
        tick;
        memReply(1'b0, 128'h0);
        checkOutput("mr_new_done", bus.S_IMEM_done_o, 1);
        checkOutput("mr_new_data", bus.S_IMEM_data_o, WLINE);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 128'h0);
        tick;

        // Spurious memory completion while idle is ignored.
        memReply(1'b1, JUNK);
        tick;
        checkOutput("sp_idone_a", bus.S_IMEM_done_o, 0);
        checkOutput("sp_ddone_a", bus.S_DMEM_done_o, 0);
        checkOutput("sp_stb_a",   bus.M_MEM_strobe_o, 0);
        tick;
        checkOutput("sp_idone_b", bus.S_IMEM_done_o, 0);
        checkOutput("sp_ddone_b", bus.S_DMEM_done_o, 0);
        checkOutput("sp_idata",   bus.S_IMEM_data_o, WLINE);
        memReply(1'b0, 128'h0);
        applyStimulus(1'b1, 32'h8000_6000, 1'b0, 32'h0, 1'b0, 128'h0);
        tick;
        checkOutput("sp_new_stb",  bus.M_MEM_strobe_o, 1);
        checkOutput("sp_new_addr", bus.M_MEM_addr_o, 32'h8000_6000);
        memReply(1'b1, LINE_A5);
        tick;
        memReply(1'b0, 128'h0);
        checkOutput("sp_new_done", bus.S_IMEM_done_o, 1);
        checkOutput("sp_new_data", bus.S_IMEM_data_o, LINE_A5);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 128'h0);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
